// File: rtl/spi_read_scheduler.sv
// rtl/spi_read_scheduler.sv - clocked read sequencer for the simpleSPI sensor master
//
// Ports:
//   clk, rst_l         single clock, synchronous active-low reset
//   en                 enables the periodic refresh timer
//   req                on-demand read request (level, sampled every cycle)
//   spi_rd             read request to simpleSPI, held until spi_d_ready is seen
//   spi_d_ready, spi_d frame-complete level and 16-bit frame from simpleSPI
//   sample, als        last captured frame and its light field sample[12:5]
//   sample_vld         one-cycle pulse when sample/als update
//   err_timeout        one-cycle pulse when REQ or RELEASE is aborted
//   overrun            one-cycle pulse when a trigger is dropped
//   busy               high whenever a transaction is in flight
module spi_read_scheduler #(
  parameter int REFRESH_CYCLES = 40_000,
  parameter int TIMEOUT_CYCLES = 10_000
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        en,
  input  logic        req,
  output logic        spi_rd,
  input  logic        spi_d_ready,
  input  logic [15:0] spi_d,
  output logic [15:0] sample,
  output logic [7:0]  als,
  output logic        sample_vld,
  output logic        err_timeout,
  output logic        overrun,
  output logic        busy
);

  localparam int TMR_W = $clog2(REFRESH_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [TO_W-1:0]  to_cnt;
  logic             pending;
  logic             tick;
  logic             trigger;
  logic             to_hit;

  assign tick    = en && (tmr == TMR_LAST);
  assign trigger = tick || req;
  assign to_hit  = (to_cnt == TO_LAST);

  // Free-running refresh timer; independent of the transaction FSM.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      tmr <= '0;
    end else if (!en || tick) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state       <= IDLE;
      pending     <= 1'b0;
      to_cnt      <= '0;
      spi_rd      <= 1'b0;
      busy        <= 1'b0;
      sample      <= 16'h0000;
      als         <= 8'h00;
      sample_vld  <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sample_vld  <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= trigger && pending;

      // Single pending slot: a trigger seen while it is full is dropped,
      // and the slot is drained only from IDLE.
      if (pending) begin
        if (state == IDLE) begin
          pending <= 1'b0;
        end
      end else if (trigger) begin
        pending <= 1'b1;
      end

      // Saturating so a stuck counter can never wrap back below the limit.
      if (state != IDLE && to_cnt != '1) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      case (state)
        IDLE: begin
          if (pending) begin
            state  <= REQ;
            to_cnt <= '0;
            spi_rd <= 1'b1;
            busy   <= 1'b1;
          end
        end

        REQ: begin
          // A ready level already present on entry is captured as a frame.
          if (spi_d_ready) begin
            sample     <= spi_d;
            als        <= spi_d[12:5];
            sample_vld <= 1'b1;
            state      <= RELEASE;
            spi_rd     <= 1'b0;
            to_cnt     <= '0;
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            state       <= RELEASE;
            spi_rd      <= 1'b0;
            to_cnt      <= '0;
          end
        end

        RELEASE: begin
          // Wait for the master to drop its ready level before the next read.
          if (!spi_d_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          spi_rd <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_read_scheduler.sv
// tb/tb_spi_read_scheduler.sv - self-checking bench for spi_read_scheduler
module tb_spi_read_scheduler;

  localparam int REFRESH = 100;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        en = 1'b0;
  logic        req = 1'b0;
  logic        spi_rd;
  logic        spi_d_ready = 1'b0;
  logic [15:0] spi_d = 16'h0000;
  logic [15:0] sample;
  logic [7:0]  als;
  logic        sample_vld;
  logic        err_timeout;
  logic        overrun;
  logic        busy;

  spi_read_scheduler #(
    .REFRESH_CYCLES(REFRESH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .en(en),
    .req(req),
    .spi_rd(spi_rd),
    .spi_d_ready(spi_d_ready),
    .spi_d(spi_d),
    .sample(sample),
    .als(als),
    .sample_vld(sample_vld),
    .err_timeout(err_timeout),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 requesting, 2 releasing; age counts cycles in phase.
  int          m_tmr = 0;
  bit          m_pending = 0;
  int          m_phase = 0;
  int          m_age = 0;
  logic [15:0] m_sample = 16'h0000;
  bit          m_vld = 0;
  bit          m_err = 0;
  bit          m_ovr = 0;

  task automatic model_step(input bit r, input bit e, input bit q, input bit rdy, input logic [15:0] d);
    bit tk;
    bit trig;
    int nphase;
    if (!r) begin
      m_tmr = 0; m_pending = 0; m_phase = 0; m_age = 0;
      m_sample = 16'h0000; m_vld = 0; m_err = 0; m_ovr = 0;
      return;
    end
    tk = e && (m_tmr == REFRESH - 1);
    trig = tk || q;
    m_ovr = trig && m_pending;
    m_vld = 0;
    m_err = 0;
    nphase = m_phase;
    case (m_phase)
      0: if (m_pending) begin nphase = 1; m_age = 0; end
      1: begin
        if (rdy) begin m_sample = d; m_vld = 1; nphase = 2; m_age = 0; end
        else if (m_age == TIMEOUT - 1) begin m_err = 1; nphase = 2; m_age = 0; end
        else m_age++;
      end
      default: begin
        if (!rdy) nphase = 0;
        else if (m_age == TIMEOUT - 1) begin m_err = 1; nphase = 0; end
        else m_age++;
      end
    endcase
    m_pending = m_pending ? (m_phase != 0) : trig;
    m_phase = nphase;
    m_tmr = e ? (m_tmr + 1) % REFRESH : 0;
  endtask

  // SPI master stand-in: mode 0/1 fixed frames, 2 random, 3 never answers.
  int          sl_mode = 0;
  int          sl_cnt = 0;
  int          sl_lat = 40;
  int          sl_hold = 2;
  bit          sl_ready = 0;
  logic [15:0] sl_data = 16'h0AA0;

  task automatic pick_params();
    case (sl_mode)
      0: begin sl_lat = 40; sl_data = 16'h0AA0; sl_hold = 2; end
      1: begin sl_lat = 40; sl_data = 16'h1FE0; sl_hold = 3; end
      2: begin
        sl_lat = $urandom_range(1, 60);
        sl_data = 16'($urandom);
        sl_hold = ($urandom_range(0, 7) == 0) ? 55 : $urandom_range(0, 4);
      end
      default: begin sl_lat = 1_000_000; sl_data = 16'h0; sl_hold = 0; end
    endcase
  endtask

  task automatic slave_update();
    if (!sl_ready) begin
      if (spi_rd && sl_mode != 3) begin
        sl_cnt++;
        if (sl_cnt >= sl_lat) sl_ready = 1;
      end else if (!spi_rd) begin
        sl_cnt = 0;
      end
    end else if (!spi_rd) begin
      if (sl_hold == 0) begin
        sl_ready = 0;
        sl_cnt = 0;
        pick_params();
      end else begin
        sl_hold--;
      end
    end
    spi_d_ready = sl_ready;
    spi_d = sl_ready ? sl_data : 16'($urandom);
  endtask

  int cnt_vld = 0;
  int cnt_err = 0;
  int cnt_ovr = 0;
  int cnt_rise = 0;
  bit prev_rd = 0;

  task automatic clear_counts();
    cnt_vld = 0; cnt_err = 0; cnt_ovr = 0; cnt_rise = 0;
  endtask

  task automatic cycle(input bit r, input bit e, input bit q);
    @(negedge clk);
    check("spi_rd", 32'(spi_rd), 32'(m_phase == 1));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("sample", 32'(sample), 32'(m_sample));
    check("als", 32'(als), 32'(m_sample[12:5]));
    check("sample_vld", 32'(sample_vld), 32'(m_vld));
    check("err_timeout", 32'(err_timeout), 32'(m_err));
    check("overrun", 32'(overrun), 32'(m_ovr));
    cnt_vld += int'(sample_vld);
    cnt_err += int'(err_timeout);
    cnt_ovr += int'(overrun);
    if (spi_rd && !prev_rd) cnt_rise++;
    prev_rd = spi_rd;
    rst_l = r;
    en = e;
    req = q;
    slave_update();
    @(posedge clk);
    model_step(r, e, q, spi_d_ready, spi_d);
  endtask

  task automatic set_mode(input int m);
    sl_mode = m;
    pick_params();
  endtask

  initial begin
    int guard;
    bit rnd_en;

    set_mode(0);
    @(posedge clk);
    repeat (3) cycle(0, 0, 0);

    // Periodic refresh: four reads in 450 cycles, fixed frame, no overrun.
    clear_counts();
    repeat (450) cycle(1, 1, 0);
    repeat (5) cycle(1, 0, 0);
    check("periodic_vld_count", 32'(cnt_vld), 32'd4);
    check("periodic_overrun", 32'(cnt_ovr), 32'd0);
    check("periodic_sample", 32'(sample), 32'h0AA0);
    check("periodic_als", 32'(als), 32'h55);

    // On-demand single request.
    set_mode(1);
    clear_counts();
    cycle(1, 0, 1);
    repeat (60) cycle(1, 0, 0);
    check("demand_vld_count", 32'(cnt_vld), 32'd1);
    check("demand_als", 32'(als), 32'hFF);
    check("demand_busy_end", 32'(busy), 32'd0);

    // Tick and req in the same cycle give exactly one read.
    guard = 0;
    while (m_tmr != REFRESH - 1 && guard < 200) begin
      cycle(1, 1, 0);
      guard++;
    end
    check("tick_align_in_time", 32'(guard < 200), 32'd1);
    clear_counts();
    cycle(1, 1, 1);
    repeat (80) cycle(1, 0, 0);
    check("simul_vld_count", 32'(cnt_vld), 32'd1);
    check("simul_rise_count", 32'(cnt_rise), 32'd1);
    check("simul_overrun", 32'(cnt_ovr), 32'd0);

    // Two extra triggers mid-transaction: one queued, one dropped.
    clear_counts();
    cycle(1, 0, 1);
    repeat (10) cycle(1, 0, 0);
    cycle(1, 0, 1);
    repeat (5) cycle(1, 0, 0);
    cycle(1, 0, 1);
    repeat (150) cycle(1, 0, 0);
    check("queue_vld_count", 32'(cnt_vld), 32'd2);
    check("queue_overrun_count", 32'(cnt_ovr), 32'd1);

    // Timeout with a silent master, then recovery.
    set_mode(3);
    clear_counts();
    cycle(1, 0, 1);
    repeat (120) cycle(1, 0, 0);
    check("timeout_err_count", 32'(cnt_err), 32'd1);
    check("timeout_vld_count", 32'(cnt_vld), 32'd0);
    check("timeout_sample_kept", 32'(sample), 32'h1FE0);
    set_mode(1);
    clear_counts();
    cycle(1, 0, 1);
    repeat (60) cycle(1, 0, 0);
    check("recover_vld_count", 32'(cnt_vld), 32'd1);

    // Reset in the middle of REQ.
    clear_counts();
    cycle(1, 0, 1);
    repeat (10) cycle(1, 0, 0);
    cycle(0, 0, 0);
    #1;
    check("midrst_spi_rd", 32'(spi_rd), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sample", 32'(sample), 32'd0);
    check("midrst_err", 32'(err_timeout), 32'd0);
    clear_counts();
    repeat (60) cycle(1, 0, 0);
    check("midrst_no_err", 32'(cnt_err), 32'd0);
    check("midrst_no_vld", 32'(cnt_vld), 32'd0);
    check("midrst_no_restart", 32'(cnt_rise), 32'd0);

    // Randomized traffic against the model.
    set_mode(2);
    rnd_en = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) rnd_en = !rnd_en;
      cycle(($urandom_range(0, 799) != 0), rnd_en, ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
